// File: rtl/dmem_responder.sv
// Single-port word memory behind a req/ack handshake with a fixed number of wait states.
// Errors (misaligned or out-of-range addresses) are reported in the ack cycle and never touch storage.
module dmem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [3:0]            wait_cnt;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           mem [DEPTH];

    logic                  src_we;
    logic [31:0]           src_addr;
    logic                  src_err;
    logic [DEPTH_LOG2-1:0] src_idx;
    logic                  enter_resp;

    // In IDLE the live inputs are the ones about to be captured (matters when there are no wait states).
    assign src_we   = (state == IDLE) ? we   : we_q;
    assign src_addr = (state == IDLE) ? addr : addr_q;
    assign src_err  = (src_addr[1:0] != 2'b00) || ((src_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign src_idx  = src_addr[DEPTH_LOG2+1:2];
    assign busy     = (state != IDLE);

    always_comb begin
        enter_resp = 1'b0;
        if (state == IDLE) begin
            enter_resp = req && (WAIT_CYCLES == 0);
        end else if (state == WAIT) begin
            enter_resp = (wait_cnt <= 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            ack      <= 1'b0;
            rdata    <= 32'd0;
            err      <= 1'b0;
        end else begin
            ack   <= 1'b0;
            rdata <= 32'd0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        addr_q   <= addr;
                        wdata_q  <= wdata;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= enter_resp ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (enter_resp) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // Response outputs are registered so they appear exactly during RESP.
            if (enter_resp) begin
                ack   <= 1'b1;
                err   <= src_err;
                rdata <= (!src_we && !src_err) ? mem[src_idx] : 32'd0;
            end
        end
    end

    // Writes commit at the edge that ends RESP, so a reset during WAIT leaves storage untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (state == RESP && we_q && !src_err) begin
            mem[src_idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a 2-wait-state instance driven by directed and random
// transactions against an array model, plus a zero-wait-state instance for the pipelined case.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, ack, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic        req0, we0, ack0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_mem [64];

    dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_is_bad(input logic [31:0] a);
        return ((a & 32'd3) != 32'd0) || (a >= 32'd256);
    endfunction

    // One transaction on the 2-wait-state instance. exp_lat counts sample points (#1 after each
    // edge) from the call until ack: 3 from an idle start, 4 when called in the ack cycle.
    task automatic apply_stimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                  input int exp_lat, input logic scramble, input string tag);
        int          lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        exp_err = addr_is_bad(a);
        exp_rd  = (!w && !exp_err) ? model_mem[a[7:2]] : 32'd0;
        if (w && !exp_err) model_mem[a[7:2]] = d;
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                break;
            end
            check_output({tag, "_busy"}, 32'(busy), 32'(n > exp_lat - 3));
            if (scramble && n == exp_lat - 2) begin
                addr = $urandom; wdata = $urandom; we = ~w;
            end
        end
        check_output({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_output({tag, "_rdata"}, rdata, exp_rd);
        check_output({tag, "_err"}, 32'(err), 32'(exp_err));
        check_output({tag, "_busy_ack"}, 32'(busy), 32'd1);
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    endtask

    initial begin
        int          g;
        int          r;
        int          acks;
        logic [31:0] a;

        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ack", 32'(ack), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_busy0", 32'(busy0), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // First request after reset, then write/read back-to-back.
        apply_stimulus(1'b0, 32'h10, 32'd0, 3, 1'b0, "rd10");
        apply_stimulus(1'b1, 32'h4, 32'hDEADBEEF, 4, 1'b0, "wr4");
        apply_stimulus(1'b0, 32'h4, 32'd0, 4, 1'b0, "rd4_b2b");

        // Error writes must leave storage alone.
        apply_stimulus(1'b1, 32'h6, 32'h11111111, 4, 1'b0, "wr_mis");
        apply_stimulus(1'b1, 32'h100, 32'h22222222, 4, 1'b0, "wr_oor");
        apply_stimulus(1'b0, 32'h4, 32'd0, 4, 1'b0, "rd4_after_err");
        apply_stimulus(1'b0, 32'h0, 32'd0, 4, 1'b0, "rd0_after_err");
        apply_stimulus(1'b0, 32'h3, 32'd0, 4, 1'b0, "rd_mis");

        // Inputs scrambled during WAIT must not affect the transaction.
        @(posedge clk); #1;
        apply_stimulus(1'b1, 32'hC, 32'hCAFEF00D, 3, 1'b1, "wr_scr");
        apply_stimulus(1'b0, 32'hC, 32'd0, 4, 1'b1, "rd_scr");

        for (int i = 0; i < 40; i++) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk); #1;
            end
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 63)) << 2;
            if (r == 7) a = a + 32'($urandom_range(1, 3));
            else if (r > 7) a = 32'($urandom_range(64, 1000)) << 2;
            apply_stimulus(1'($urandom_range(0, 1)), a, $urandom, (g == 0) ? 4 : 3, 1'($urandom_range(0, 1)), "rnd");
        end

        // Reset during WAIT of a write: no ack, nothing committed, storage cleared.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'h12345678;
        @(posedge clk); #1;
        check_output("mid_rst_busy_before", 32'(busy), 32'd1);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_ack", 32'(ack), 32'd0);
        req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        for (int i = 0; i < 64; i++) model_mem[i] = 32'd0;
        acks = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        check_output("mid_rst_no_ack", 32'(acks), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        apply_stimulus(1'b0, 32'h8, 32'd0, 3, 1'b0, "rd8_after_rst");
        apply_stimulus(1'b0, 32'h4, 32'd0, 4, 1'b0, "rd4_after_rst");

        // Zero-wait-state instance: ack one sample after capture, every 2nd cycle when req is held.
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hA5A55A5A;
        @(posedge clk); #1;
        check_output("w0_wr_ack", 32'(ack0), 32'd1);
        check_output("w0_wr_err", 32'(err0), 32'd0);
        check_output("w0_wr_rdata", rdata0, 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        check_output("w0_idle_ack", 32'(ack0), 32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        acks = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            check_output("w0_held_ack", 32'(ack0), 32'(n % 2));
            if (ack0) begin
                acks++;
                check_output("w0_held_rdata", rdata0, 32'hA5A55A5A);
            end
        end
        check_output("w0_ack_count", 32'(acks), 32'd4);
        req0 = 1'b0;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h102;
        @(posedge clk); #1;
        check_output("w0_err_ack", 32'(ack0), 32'd1);
        check_output("w0_err_flag", 32'(err0), 32'd1);
        check_output("w0_err_rdata", rdata0, 32'd0);
        req0 = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 6, log2 of the word count of storage (64 x 32-bit words).
REQ-002 Parameter: WAIT_CYCLES, default 2, wait states inserted between request capture and ack (legal 0..15).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: req  input  1  initiator request; held high with we/addr/wdata stable until ack is seen.
REQ-006 Port: we  input  1  1 = write, 0 = read.
REQ-007 Port: addr  input  32  byte address; word index = addr[DEPTH_LOG2+1:2].
REQ-008 Port: wdata  input  32  write data.
REQ-009 Port: ack  output  1  one-cycle completion pulse.
REQ-010 Port: rdata  output  32  read data, valid only while ack=1, else 0.
REQ-011 Port: err  output  1  error flag, valid only while ack=1, else 0.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP; the registered outputs ack, rdata and err SHALL be driven only from RESP.
REQ-014 In IDLE with req=1 at an edge, the block SHALL latch we, addr and wdata, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP directly if WAIT_CYCLES=0.
REQ-015 In WAIT, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL go to RESP, giving ack high in cycle k+WAIT_CYCLES+1 for a request sampled at edge k.
REQ-016 RESP SHALL last exactly one cycle (ack=1) and then return to IDLE.
REQ-017 Input changes after capture SHALL be ignored; only the latched values are used.
REQ-018 Error SHALL be flagged when the latched addr[1:0]!=0 or the latched addr[31:DEPTH_LOG2+2]!=0.
REQ-019 Read without error: rdata = mem[index], err=0 during ack.
REQ-020 Write without error: mem[index] <= wdata at the edge ending RESP; rdata=0, err=0.
REQ-021 Any error: no storage change, rdata=0, err=1 during ack.
REQ-022 A req seen in the cycle after ack (IDLE) SHALL start a new transaction, so back-to-back transfers cost WAIT_CYCLES+2 cycles each.
REQ-023 req sampled in WAIT or RESP SHALL be ignored; there is no queueing.
REQ-024 A read of an address in the same transaction stream immediately after a write to it SHALL return the new data.

Reset
REQ-025 rst_n=0 SHALL, asynchronously, force the FSM to IDLE, counter to 0, ack=0, rdata=0, err=0, busy=0 and all storage words to 0.
REQ-026 Reset asserted mid-transaction SHALL abort it with no write committed and no ack issued.
REQ-027 After rst_n rises, the first req SHALL be captured at the first rising edge at which rst_n=1 and req=1.

Verification
REQ-028 Reset, then read addr 0x0000_0010 -> ack in cycle k+3, rdata=0x0000_0000, err=0, busy high for cycles k+1..k+3.
REQ-029 Write 0xDEADBEEF to 0x0000_0004, then read 0x0000_0004 back-to-back -> second ack 4 cycles after the first, rdata=0xDEADBEEF.
REQ-030 Write to misaligned 0x0000_0006 and to out-of-range 0x0000_0100 -> ack with err=1, rdata=0; a following read of 0x0000_0004 still returns 0xDEADBEEF and 0x0000_0000 is unchanged.
REQ-031 WAIT_CYCLES=0 build: read sampled at edge k -> ack in cycle k+1; req held high continuously -> ack every 2nd cycle.
REQ-032 Assert rst_n=0 during WAIT of a write 0x12345678 to 0x0000_0008 -> no ack; after reset, read 0x0000_0008 returns 0.
REQ-033 Change addr/wdata during WAIT -> response reflects the values latched at capture.
